my_display_scanner: RTL and testbench

- Parametrised, time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits on the DE0 board.
- Takes a packed BCD word plus per-digit decimal points and scans one digit at a time at a programmable refresh rate.
- Supports atomic frame-aligned updates, leading-zero blanking and whole-display blink.
- Sits between the datapath (counters/ALU results) and the board HEX/anode pins; replaces per-digit static combinational encoders.

---
 rtl/my_display_scanner_if.sv | 26 ++
 rtl/my_display_scanner.sv | 130 +++++++++++++
 tb/tb_my_display_scanner.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/my_display_scanner_if.sv
// my_display_scanner_if: datapath-side and pin-side signals of the 7-segment scanner.
interface my_display_scanner_if #(
    parameter int NUM_DIGITS          = 4,
    parameter int DECIMAL_DIGIT_WIDTH = 4,
    parameter int ENCODING_WIDTH      = 8
);
    logic                                      i_load;
    logic [NUM_DIGITS*DECIMAL_DIGIT_WIDTH-1:0] i_digits_in;
    logic [NUM_DIGITS-1:0]                     i_dp_in;
    logic                                      i_lz_blank;
    logic                                      i_blink_en;
    logic [ENCODING_WIDTH-1:0]                 o_seg;
    logic [NUM_DIGITS-1:0]                     o_an;
    logic                                      o_pending;
    logic                                      o_frame_done;

    modport master (
        output i_load, i_digits_in, i_dp_in, i_lz_blank, i_blink_en,
        input  o_seg, o_an, o_pending, o_frame_done
    );

    modport slave (
        input  i_load, i_digits_in, i_dp_in, i_lz_blank, i_blink_en,
        output o_seg, o_an, o_pending, o_frame_done
    );
endinterface

// File: rtl/my_display_scanner.sv
// my_display_scanner: time-multiplexed common-anode 7-segment driver with
// frame-aligned double-buffered loads, leading-zero blanking and blink.
module my_display_scanner #(
    parameter int NUM_DIGITS          = 4,
    parameter int DECIMAL_DIGIT_WIDTH = 4,
    parameter int ENCODING_WIDTH      = 8,
    parameter int REFRESH_DIV         = 50000,
    parameter int BLINK_FRAMES        = 64
) (
    input logic              clk,
    input logic              rst_n,
    my_display_scanner_if.slave bus
);
    localparam int DDW = DECIMAL_DIGIT_WIDTH;
    localparam int DW  = NUM_DIGITS * DDW;
    localparam int CW  = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int IW  = $clog2(NUM_DIGITS);
    localparam int FW  = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]             r_cnt;
    logic [IW-1:0]             r_idx;
    logic [FW-1:0]             r_fcnt;
    logic                      r_blink_on;
    logic                      r_frame_done;
    logic [DW-1:0]             r_act;
    logic [NUM_DIGITS-1:0]     r_act_dp;
    logic [DW-1:0]             r_pend_val;
    logic [NUM_DIGITS-1:0]     r_pend_dp;
    logic                      r_pend;
    logic [ENCODING_WIDTH-1:0] r_seg;
    logic [NUM_DIGITS-1:0]     r_an;

    logic                      w_tick;
    logic                      w_wrap;
    logic                      w_fwrap;
    logic [DDW-1:0]            w_sel;
    logic                      w_lz;
    logic [ENCODING_WIDTH-1:0] w_seg;
    logic [NUM_DIGITS-1:0]     w_an;

    function automatic logic [6:0] seg7(input logic [DDW-1:0] v);
        case (int'(v))
            0:       return 7'h40;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            9:       return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    assign w_tick  = r_cnt == CW'(REFRESH_DIV - 1);
    assign w_wrap  = w_tick && r_idx == IW'(NUM_DIGITS - 1);
    assign w_fwrap = r_fcnt == FW'(BLINK_FRAMES - 1);
    assign w_sel   = r_act[r_idx*DDW +: DDW];
    // Shifting the selected digit to the bottom leaves zero only if it and all higher digits are zero.
    assign w_lz    = bus.i_lz_blank && r_idx != '0 && (r_act >> (r_idx*DDW)) == '0;
    assign w_an    = ~(NUM_DIGITS'(1) << r_idx);

    always_comb begin
        w_seg = '1;
        if (!(bus.i_blink_en && !r_blink_on)) begin
            w_seg[7]   = ~r_act_dp[r_idx];
            w_seg[6:0] = w_lz ? 7'h7F : seg7(w_sel);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_fcnt       <= '0;
            r_blink_on   <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_tick ? '0 : r_cnt + 1'b1;
            r_frame_done <= w_wrap;
            if (w_tick)
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            if (w_wrap) begin
                r_fcnt <= w_fwrap ? '0 : r_fcnt + 1'b1;
                if (w_fwrap)
                    r_blink_on <= ~r_blink_on;
            end
        end
    end

    // Active data only changes on a frame boundary so a frame never mixes two loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act      <= '0;
            r_act_dp   <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend     <= 1'b0;
        end else if (w_wrap && bus.i_load) begin
            r_act    <= bus.i_digits_in;
            r_act_dp <= bus.i_dp_in;
            r_pend   <= 1'b0;
        end else if (w_wrap && r_pend) begin
            r_act    <= r_pend_val;
            r_act_dp <= r_pend_dp;
            r_pend   <= 1'b0;
        end else if (bus.i_load) begin
            r_pend_val <= bus.i_digits_in;
            r_pend_dp  <= bus.i_dp_in;
            r_pend     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= '1;
            r_an  <= '1;
        end else begin
            r_seg <= w_seg;
            r_an  <= w_an;
        end
    end

    assign bus.o_seg        = r_seg;
    assign bus.o_an         = r_an;
    assign bus.o_pending    = r_pend;
    assign bus.o_frame_done = r_frame_done;
endmodule

// File: tb/tb_my_display_scanner.sv
// tb_my_display_scanner: random and directed stimulus against a cycle-indexed
// reference model; expectations are queued at each edge and checked by a monitor.
module tb_my_display_scanner;
    localparam int N  = 4;
    localparam int R  = 4;
    localparam int BF = 2;
    localparam int RN = R * N;
    localparam logic [7:0] LUT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    typedef struct {
        logic [7:0] seg;
        logic [3:0] an;
        logic       pend;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   k = 0;
    exp_t q[$];
    logic [15:0] m_act, m_pv;
    logic [3:0]  m_adp, m_pdp;
    logic        m_pend;

    my_display_scanner_if #(.NUM_DIGITS(N), .DECIMAL_DIGIT_WIDTH(4), .ENCODING_WIDTH(8)) bus ();

    my_display_scanner #(
        .NUM_DIGITS(N), .DECIMAL_DIGIT_WIDTH(4), .ENCODING_WIDTH(8),
        .REFRESH_DIV(R), .BLINK_FRAMES(BF)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int d, input logic [15:0] a, input logic [3:0] dp,
                                           input logic lz, input logic off);
        logic [15:0] hi;
        int v;
        logic [7:0] code;
        hi = a >> (4 * d);
        v  = int'(hi & 16'hF);
        if (off) return 8'hFF;
        code = (v > 9 || (lz && d > 0 && hi == 16'h0)) ? 8'hFF : LUT[v];
        return {~dp[d], code[6:0]};
    endfunction

    // Reference: state after edge k shows digit ((k-1)/R)%N with the data that was active before that edge.
    always @(posedge clk) begin
        exp_t e;
        int d, f;
        logic bnd;
        if (!rst_n) begin
            k = 0; m_act = '0; m_adp = '0; m_pv = '0; m_pdp = '0; m_pend = 1'b0;
            e = '{8'hFF, 4'hF, 1'b0, 1'b0};
        end else begin
            k++;
            d   = ((k - 1) / R) % N;
            f   = (k - 1) / RN;
            bnd = (k % RN) == 0;
            e.an  = ~(4'b1 << d);
            e.seg = exp_seg(d, m_act, m_adp, bus.i_lz_blank, bus.i_blink_en && ((f / BF) % 2 == 1));
            e.fd  = bnd;
            if (bnd && bus.i_load) begin
                m_act = bus.i_digits_in; m_adp = bus.i_dp_in; m_pend = 1'b0;
            end else if (bnd && m_pend) begin
                m_act = m_pv; m_adp = m_pdp; m_pend = 1'b0;
            end else if (bus.i_load) begin
                m_pv = bus.i_digits_in; m_pdp = bus.i_dp_in; m_pend = 1'b1;
            end
            e.pend = m_pend;
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("seg", 32'(bus.o_seg), 32'(e.seg));
            chk("an", 32'(bus.o_an), 32'(e.an));
            chk("pending", 32'(bus.o_pending), 32'(e.pend));
            chk("frame_done", 32'(bus.o_frame_done), 32'(e.fd));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        bus.i_load = 1'b1;
        bus.i_digits_in = v;
        bus.i_dp_in = dp;
        cyc(1);
        bus.i_load = 1'b0;
    endtask

    task automatic to_boundary();
        for (int i = 0; i < RN && ((k + 1) % RN) != 0; i++) cyc(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.i_load = 1'b0; bus.i_digits_in = '0; bus.i_dp_in = '0;
        bus.i_lz_blank = 1'b0; bus.i_blink_en = 1'b0;
        cyc(3);
        chk("reset_seg", 32'(bus.o_seg), 32'hFF);
        chk("reset_an", 32'(bus.o_an), 32'hF);
        rst_n = 1'b1;
        cyc(40);
        do_load(16'h1234, 4'b0100);
        chk("pending_set", 32'(bus.o_pending), 32'h1);
        cyc(40);
        bus.i_lz_blank = 1'b1;
        do_load(16'h0070, 4'b0000);
        cyc(40);
        do_load(16'h0000, 4'b0000);
        cyc(40);
        bus.i_lz_blank = 1'b0;
        do_load(16'h000A, 4'b0000);
        cyc(36);
        to_boundary();
        do_load(16'h5678, 4'b0001);
        cyc(3);
        do_load(16'h1111, 4'b0000);
        cyc(3);
        do_load(16'h2222, 4'b0000);
        cyc(40);
        bus.i_blink_en = 1'b1;
        do_load(16'h4321, 4'b1000);
        cyc(200);
        bus.i_blink_en = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (c % 100 == 0) begin
                bus.i_lz_blank = 1'($urandom_range(0, 1));
                bus.i_blink_en = 1'($urandom_range(0, 1));
            end
            bus.i_load = ($urandom_range(0, 9) == 0);
            bus.i_digits_in = 16'($urandom);
            bus.i_dp_in = 4'($urandom);
            if ($urandom_range(0, 3) == 0) bus.i_digits_in[15:8] = 8'h00;
            cyc(1);
        end
        bus.i_load = 1'b0;
        bus.i_blink_en = 1'b0;
        bus.i_lz_blank = 1'b0;
        cyc(5);
        to_boundary();
        cyc(5);
        do_load(16'h9999, 4'hF);
        chk("pending_before_reset", 32'(bus.o_pending), 32'h1);
        #5;
        rst_n = 1'b0;
        #1;
        chk("async_seg", 32'(bus.o_seg), 32'hFF);
        chk("async_an", 32'(bus.o_an), 32'hF);
        chk("async_pending", 32'(bus.o_pending), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(80);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
